// File: rtl/ub_writeback_packer.sv
// Packs an int8 result stream into LANES-byte unified-buffer words and writes them to
// auto-incrementing addresses through a small FIFO. Define UB_BYTE_EN_EN to add per-lane byte enables.
module ub_writeback_packer #(
    parameter int LANES      = 4,
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [7:0]            cfg_pad,
    input  logic                  in_valid,
    input  logic signed [7:0]     in_data,
    output logic                  ub_wr_en,
    output logic [ADDR_W-1:0]     ub_wr_addr,
    output logic [8*LANES-1:0]    ub_wr_data,
`ifdef UB_BYTE_EN_EN
    output logic [LANES-1:0]      ub_wr_be,
`endif
    input  logic                  ub_wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 8 * LANES;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          pad_q, pad_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [WORD_W-1:0]   asm_q, asm_d;

    logic [WORD_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                ub_wr_en_q, ub_wr_en_d;
    logic [ADDR_W-1:0]   ub_wr_addr_q, ub_wr_addr_d;
    logic [WORD_W-1:0]   ub_wr_data_q, ub_wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;

`ifdef UB_BYTE_EN_EN
    logic [LANES-1:0]    mem_be_q [FIFO_DEPTH];
    logic [LANES-1:0]    mem_be_d [FIFO_DEPTH];
    logic [LANES-1:0]    ub_wr_be_q, ub_wr_be_d;
    logic [LANES-1:0]    push_be;
`endif

    logic                push, push_ok, pop, fifo_full, last_byte;
    logic [WORD_W-1:0]   push_word;
    logic [ADDR_W-1:0]   push_addr;
    logic [CNT_W-1:0]    remaining;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        pad_d        = pad_q;
        byte_cnt_d   = byte_cnt_q;
        lane_d       = lane_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        mem_data_d   = mem_data_q;
        mem_addr_d   = mem_addr_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        last_byte    = 1'b0;
        push_word    = '0;
        push_addr    = base_q + word_idx_q;
        pop          = ub_wr_en_q && ub_wr_ready;
`ifdef UB_BYTE_EN_EN
        mem_be_d     = mem_be_q;
        push_be      = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = cfg_base_addr;
                    len_d      = cfg_len;
                    pad_d      = cfg_pad;
                    overflow_d = 1'b0;
                    byte_cnt_d = '0;
                    lane_d     = '0;
                    word_idx_d = '0;
                    asm_d      = '0;
                    state_d    = (cfg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    // Lanes below the current one are already assembled; lanes above only exist on a short final word.
                    for (int i = 0; i < LANES; i++) begin
                        if (i < int'(lane_q))
                            push_word[8*i +: 8] = asm_q[8*i +: 8];
                        else if (i == int'(lane_q))
                            push_word[8*i +: 8] = in_data;
                        else
                            push_word[8*i +: 8] = pad_q;
`ifdef UB_BYTE_EN_EN
                        push_be[i] = (i <= int'(lane_q));
`endif
                    end
                    asm_d[8*int'(lane_q) +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    last_byte  = (byte_cnt_d == len_q);
                    if (last_byte || lane_q == LANE_W'(LANES - 1)) begin
                        push       = 1'b1;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        lane_d     = '0;
                    end else begin
                        lane_d     = lane_q + LANE_W'(1);
                    end
                    if (last_byte)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (in_valid)
                    overflow_d = 1'b1;
                if (count_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A full FIFO still accepts a push when the head is popped in the same cycle.
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok   = push && (!fifo_full || pop);
        if (push && !push_ok)
            overflow_d = 1'b1;
        if (push_ok) begin
            mem_data_d[wptr_q] = push_word;
            mem_addr_d[wptr_q] = push_addr;
`ifdef UB_BYTE_EN_EN
            mem_be_d[wptr_q]   = push_be;
`endif
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop)
            rptr_d = rptr_q + PTR_W'(1);
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        remaining = count_q - CNT_W'(pop);

        // Output registers mirror the next head; an empty FIFO bypasses the pushed word straight to them.
        if (count_d == '0) begin
            ub_wr_en_d   = 1'b0;
            ub_wr_addr_d = '0;
            ub_wr_data_d = '0;
`ifdef UB_BYTE_EN_EN
            ub_wr_be_d   = '0;
`endif
        end else if (remaining == '0) begin
            ub_wr_en_d   = 1'b1;
            ub_wr_addr_d = push_addr;
            ub_wr_data_d = push_word;
`ifdef UB_BYTE_EN_EN
            ub_wr_be_d   = push_be;
`endif
        end else begin
            ub_wr_en_d   = 1'b1;
            ub_wr_addr_d = mem_addr_q[rptr_d];
            ub_wr_data_d = mem_data_q[rptr_d];
`ifdef UB_BYTE_EN_EN
            ub_wr_be_d   = mem_be_q[rptr_d];
`endif
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            pad_q        <= '0;
            byte_cnt_q   <= '0;
            lane_q       <= '0;
            word_idx_q   <= '0;
            asm_q        <= '0;
            mem_data_q   <= '{default: '0};
            mem_addr_q   <= '{default: '0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ub_wr_en_q   <= 1'b0;
            ub_wr_addr_q <= '0;
            ub_wr_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef UB_BYTE_EN_EN
            mem_be_q     <= '{default: '0};
            ub_wr_be_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            pad_q        <= pad_d;
            byte_cnt_q   <= byte_cnt_d;
            lane_q       <= lane_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            mem_data_q   <= mem_data_d;
            mem_addr_q   <= mem_addr_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ub_wr_en_q   <= ub_wr_en_d;
            ub_wr_addr_q <= ub_wr_addr_d;
            ub_wr_data_q <= ub_wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
`ifdef UB_BYTE_EN_EN
            mem_be_q     <= mem_be_d;
            ub_wr_be_q   <= ub_wr_be_d;
`endif
        end
    end

    assign ub_wr_en   = ub_wr_en_q;
    assign ub_wr_addr = ub_wr_addr_q;
    assign ub_wr_data = ub_wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
`ifdef UB_BYTE_EN_EN
    assign ub_wr_be   = ub_wr_be_q;
`endif

endmodule

// File: tb/tb_ub_writeback_packer.sv
// Bench for ub_writeback_packer: directed and randomized transfers scored against a word-list model
// built from the packing rules (bytes in lane order, pad fill, wrapping addresses).
module tb_ub_writeback_packer;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_base_addr = '0;
    logic [15:0] cfg_len = '0;
    logic [7:0]  cfg_pad = '0;
    logic        in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic        ub_wr_en;
    logic [7:0]  ub_wr_addr;
    logic [31:0] ub_wr_data;
    logic        ub_wr_ready = 1'b1;
    logic        busy, done, overflow;
`ifdef UB_BYTE_EN_EN
    logic [3:0]  ub_wr_be;
`endif

    ub_writeback_packer #(.LANES(4), .ADDR_W(8), .LEN_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_pad(cfg_pad),
        .in_valid(in_valid), .in_data(in_data),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
`ifdef UB_BYTE_EN_EN
        .ub_wr_be(ub_wr_be),
`endif
        .ub_wr_ready(ub_wr_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;

    logic [7:0]  src [$];
    logic [7:0]  got_addr [$];
    logic [31:0] got_data [$];
    logic [3:0]  got_be [$];
    logic [7:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic [3:0]  exp_be [$];

    logic        hold_pend = 1'b0;
    logic [7:0]  hold_addr;
    logic [31:0] hold_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs sampled there are those of the previous rising edge.
    task automatic tick(input logic v, input logic [7:0] d, input logic rdy, input logic st);
        @(negedge clk);
        in_valid = v;
        in_data = d;
        ub_wr_ready = rdy;
        start = st;
        cyc++;
        if (hold_pend) begin
            chk("hold_en", ub_wr_en, 1);
            chk("hold_addr", ub_wr_addr, hold_addr);
            chk("hold_data", ub_wr_data, hold_data);
        end
        if (ub_wr_en && rdy) begin
            got_addr.push_back(ub_wr_addr);
            got_data.push_back(ub_wr_data);
`ifdef UB_BYTE_EN_EN
            got_be.push_back(ub_wr_be);
`else
            got_be.push_back(4'hF);
`endif
            last_wr_cyc = cyc;
            hold_pend = 1'b0;
        end else if (ub_wr_en) begin
            hold_pend = 1'b1;
            hold_addr = ub_wr_addr;
            hold_data = ub_wr_data;
        end else begin
            hold_pend = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    function automatic logic rnd_rdy(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic build_exp(input logic [7:0] base, input int len, input logic [7:0] pad);
        int nw;
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
        nw = (len + LANES - 1) / LANES;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            logic [3:0]  be;
            word = '0;
            be = '0;
            for (int l = 0; l < LANES; l++) begin
                if (w * LANES + l < len) begin
                    word[8*l +: 8] = src[w * LANES + l];
                    be[l] = 1'b1;
                end else begin
                    word[8*l +: 8] = pad;
                end
            end
            exp_addr.push_back(8'(int'(base) + w));
            exp_data.push_back(word);
            exp_be.push_back(be);
        end
    endtask

    task automatic make_src(input int len);
        src.delete();
        for (int i = 0; i < len; i++) src.push_back(8'($urandom));
    endtask

    task automatic begin_xfer(input logic [7:0] base, input int len, input logic [7:0] pad);
        got_addr.delete(); got_data.delete(); got_be.delete();
        cfg_base_addr = base;
        cfg_len = 16'(len);
        cfg_pad = pad;
        tick(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic feed(input int first, input int last, input int gap_pct, input int rdy_pct);
        for (int i = first; i < last; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
                tick(1'b0, 8'($urandom), rnd_rdy(rdy_pct), 1'b0);
            tick(1'b1, src[i], rnd_rdy(rdy_pct), 1'b0);
        end
    endtask

    task automatic wait_done(input string tag, input int rdy_pct);
        int n;
        n = done_cnt;
        for (int k = 0; k < 300 && done_cnt == n; k++)
            tick(1'b0, 8'($urandom), rnd_rdy(rdy_pct), 1'b0);
        chk({tag, "_done_seen"}, done_cnt - n, 1);
    endtask

    task automatic compare(input string tag, input int n_exp);
        chk({tag, "_nwrites"}, got_data.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_data.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
`ifdef UB_BYTE_EN_EN
            chk($sformatf("%s_be%0d", tag, i), got_be[i], exp_be[i]);
`endif
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, ub_wr_en, 0);
        chk({tag, "_addr"}, ub_wr_addr, 0);
        chk({tag, "_data"}, ub_wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, overflow, 0);
`ifdef UB_BYTE_EN_EN
        chk({tag, "_be"}, ub_wr_be, 0);
`endif
    endtask

    initial begin
        int dc;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick(1'b0, 8'h00, 1'b1, 1'b0);

        // Two full words, back-to-back, with the first-word latency checked
        src.delete();
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        build_exp(8'h10, 8, 8'h00);
        dc = done_cnt;
        begin_xfer(8'h10, 8, 8'h00);
        for (int i = 0; i < 4; i++) tick(1'b1, src[i], 1'b1, 1'b0);
        chk("lat_pre_en", ub_wr_en, 0);
        tick(1'b1, src[4], 1'b1, 1'b0);
        chk("lat_en", ub_wr_en, 1);
        chk("lat_addr", ub_wr_addr, 8'h10);
        chk("lat_data", ub_wr_data, 32'h04030201);
        chk("t1_busy", busy, 1);
        feed(5, 8, 0, 100);
        wait_done("t1", 100);
        compare("t1", 2);
        chk("t1_data1_const", got_data[1], 32'h08070605);
        chk("t1_addr1_const", got_addr[1], 8'h11);
        chk("t1_done_once", done_cnt - dc, 1);
        chk("t1_done_after_write", done_cyc > last_wr_cyc, 1);
        chk("t1_ovf", overflow, 0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_done_drop", done, 0);
        chk("t1_idle_busy", busy, 0);

        // Partial final word filled with pad
        src.delete();
        for (int i = 1; i <= 6; i++) src.push_back(8'(i));
        build_exp(8'h30, 6, 8'h80);
        begin_xfer(8'h30, 6, 8'h80);
        feed(0, 6, 0, 100);
        wait_done("t2", 100);
        compare("t2", 2);
        chk("t2_pad_const", got_data[1], 32'h80800605);
`ifdef UB_BYTE_EN_EN
        chk("t2_be0_const", got_be[0], 4'b1111);
        chk("t2_be1_const", got_be[1], 4'b0011);
`endif

        // FIFO overflow with the UB stalled
        make_src(24);
        build_exp(8'h20, 24, 8'h00);
        begin_xfer(8'h20, 24, 8'h00);
        feed(0, 16, 0, 0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_ovf_after4", overflow, 0);
        feed(16, 20, 0, 0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_ovf_after5", overflow, 1);
        chk("t3_busy_a", busy, 1);
        feed(20, 24, 0, 0);
        for (int k = 0; k < 5; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_busy_b", busy, 1);
        chk("t3_no_writes", got_data.size(), 0);
        wait_done("t3", 100);
        compare("t3", 4);
        chk("t3_ovf_sticky", overflow, 1);

        // Address wrap with random gaps and ready toggling
        make_src(12);
        build_exp(8'hFE, 12, 8'h5A);
        begin_xfer(8'hFE, 12, 8'h5A);
        feed(0, 12, 30, 50);
        wait_done("t4", 50);
        compare("t4", 3);
        chk("t4_addr0_const", got_addr[0], 8'hFE);
        chk("t4_addr1_const", got_addr[1], 8'hFF);
        chk("t4_addr2_const", got_addr[2], 8'h00);
        chk("t4_ovf_cleared", overflow, 0);

        // Zero-length transfer
        begin_xfer(8'h40, 0, 8'h00);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_en", ub_wr_en, 0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_done_drop", done, 0);
        chk("t5_nwrites", got_data.size(), 0);

        // in_valid in IDLE is ignored; in DRAIN it raises overflow until the next start
        for (int k = 0; k < 3; k++) tick(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("t6_idle_en", ub_wr_en, 0);
        chk("t6_idle_ovf", overflow, 0);
        chk("t6_idle_busy", busy, 0);
        make_src(4);
        build_exp(8'h50, 4, 8'h00);
        begin_xfer(8'h50, 4, 8'h00);
        feed(0, 4, 0, 0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_drain_ovf", overflow, 1);
        chk("t6_drain_busy", busy, 1);
        wait_done("t6", 100);
        compare("t6", 1);
        chk("t6_ovf_sticky", overflow, 1);
        make_src(4);
        build_exp(8'h60, 4, 8'h00);
        begin_xfer(8'h60, 4, 8'h00);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_start_clears", overflow, 0);
        feed(0, 4, 0, 100);
        wait_done("t6b", 100);
        compare("t6b", 1);

        // Asynchronous reset mid-transfer with three words queued
        make_src(20);
        begin_xfer(8'h70, 20, 8'h00);
        feed(0, 13, 0, 0);
        chk("t7_pre_en", ub_wr_en, 1);
        chk("t7_pre_nwrites", got_data.size(), 0);
        dc = done_cnt;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t7_async");
        hold_pend = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t7_no_done", done_cnt - dc, 0);
        chk("t7_no_writes", got_data.size(), 0);
        make_src(4);
        build_exp(8'h08, 4, 8'h00);
        begin_xfer(8'h08, 4, 8'h00);
        feed(0, 4, 0, 100);
        wait_done("t7", 100);
        compare("t7", 1);

        // Randomized transfers that cannot overrun the FIFO
        for (int r = 0; r < 8; r++) begin
            int len;
            logic [7:0] base, pad;
            len = $urandom_range(16, 1);
            base = 8'($urandom);
            pad = 8'($urandom);
            make_src(len);
            build_exp(base, len, pad);
            begin_xfer(base, len, pad);
            feed(0, len, $urandom_range(50), $urandom_range(100, 30));
            wait_done($sformatf("rnd%0d", r), 60);
            compare($sformatf("rnd%0d", r), exp_data.size());
            chk($sformatf("rnd%0d_ovf", r), overflow, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
